// File: rtl/fifo_rd_ctrl_if.sv
// Read-side FIFO controller bus: memory read port, synchronizer input,
// read pointer feedback, and the registered output word toward the UART TX.
//
// Output handshake: rd_valid says rd_data holds an unconsumed word; a word
// transfers on every rising edge where rd_valid && rd_ready. rd_valid never
// depends combinationally on rd_ready, and rd_data is stable while
// rd_valid && !rd_ready. rd_ready may be high while rd_valid is low.
interface fifo_rd_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic [ADDR_WIDTH:0]   wptr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   rptr;
    logic                  rempty;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [ADDR_WIDTH:0]   rd_count;

    // The read controller itself
    modport master (
        input  wptr, r_data, rd_ready,
        output r_addr, rptr, rempty, rd_data, rd_valid, rd_count
    );

    // Memory, write-side synchronizer source and the consumer
    modport slave (
        output wptr, r_data, rd_ready,
        input  r_addr, rptr, rempty, rd_data, rd_valid, rd_count
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the asynchronous UART FIFO. Synchronizes the
// Gray write pointer, keeps the binary/Gray read pointer and the registered
// empty flag, and pops memory words into a registered valid/ready output.
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic           R_CLK,
    input  logic           R_RST,
    fifo_rd_ctrl_if.master bus
);

    logic [ADDR_WIDTH:0]   wq1;
    logic [ADDR_WIDTH:0]   wq2;
    logic [ADDR_WIDTH:0]   rbin;
    logic [ADDR_WIDTH:0]   rbin_next;
    logic [ADDR_WIDTH:0]   rgray_next;
    logic [ADDR_WIDTH:0]   rptr_q;
    logic                  rempty_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic                  pop;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
        logic [ADDR_WIDTH:0] b;
        b = g;
        for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Pop when memory holds a word and the output register is free or being drained.
    always_comb begin
        pop = !rempty_q && (!rd_valid_q || bus.rd_ready);
    end

    // Next read pointer in binary and Gray; the Gray form feeds both rptr and empty.
    always_comb begin
        rbin_next  = rbin + {{ADDR_WIDTH{1'b0}}, pop};
        rgray_next = rbin_next ^ (rbin_next >> 1);
    end

    // Two-flop synchronizer for the write pointer; only wq2 is used downstream.
    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            wq1 <= '0;
            wq2 <= '0;
        end else begin
            wq1 <= bus.wptr;
            wq2 <= wq1;
        end
    end

    // Read pointer and empty flag. Empty compares every bit, wrap bit included,
    // against the stale synchronized write pointer, so it can only be pessimistic.
    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            rbin     <= '0;
            rptr_q   <= '0;
            rempty_q <= 1'b1;
        end else begin
            rbin     <= rbin_next;
            rptr_q   <= rgray_next;
            rempty_q <= (rgray_next == wq2);
        end
    end

    // Output word register: load on pop (word at the current r_addr), clear valid
    // when the held word is consumed with nothing behind it, otherwise hold.
    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else if (pop) begin
            rd_data_q  <= bus.r_data;
            rd_valid_q <= 1'b1;
        end else if (rd_valid_q && bus.rd_ready) begin
            rd_valid_q <= 1'b0;
        end
    end

    assign bus.r_addr   = rbin[ADDR_WIDTH-1:0];
    assign bus.rptr     = rptr_q;
    assign bus.rempty   = rempty_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_count = gray2bin(wq2) - rbin;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: the bench owns the FIFO memory and the write
// pointer, a count-based model predicts every output each cycle, and a
// scoreboard queue checks the order of delivered words.
module tb_fifo_rd_ctrl;
    localparam int DW = 8;
    localparam int AW = 3;

    // ---------------- clock / reset ----------------
    logic R_CLK  = 1'b0;
    logic R_RST  = 1'b1;
    logic clk_en = 1'b0;
    always #5 if (clk_en) R_CLK = ~R_CLK;

    fifo_rd_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fifo_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .R_CLK (R_CLK),
        .R_RST (R_RST),
        .bus   (bus)
    );

    // Bench-owned memory with a combinational read port
    logic [DW-1:0] mem [8];
    assign bus.r_data = mem[bus.r_addr];

    int errors = 0;
    int checks = 0;
    int hs_count = 0;

    logic [AW:0]   wcnt;      // binary count of words written since reset
    logic [DW-1:0] exp_q[$];  // words still expected on the output, in order
    logic [DW-1:0] wlog[$];   // every word written since reset, by index

    function automatic logic [AW:0] to_gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // Read count, visible write count (seen two edges late, empty one edge later),
    // and the output register expressed as "k-th word read is k-th word written".
    logic [AW:0]   m_q1, m_q2, m_rcnt;
    int            m_rabs;
    logic          m_valid, m_empty;
    logic [DW-1:0] m_data;
    logic          m_pop;
    logic [AW:0]   m_rcnt_nx;
    logic [AW:0]   m_count;

    assign m_pop     = !m_empty && (!m_valid || bus.rd_ready);
    assign m_rcnt_nx = m_rcnt + {3'b000, m_pop};
    assign m_count   = m_q2 - m_rcnt;

    always @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            m_q1    <= '0;
            m_q2    <= '0;
            m_rcnt  <= '0;
            m_rabs  <= 0;
            m_valid <= 1'b0;
            m_empty <= 1'b1;
            m_data  <= '0;
        end else begin
            if (m_pop) begin
                m_data  <= (m_rabs < wlog.size()) ? wlog[m_rabs] : 'x;
                m_valid <= 1'b1;
                m_rabs  <= m_rabs + 1;
            end else if (m_valid && bus.rd_ready) begin
                m_valid <= 1'b0;
            end
            m_rcnt  <= m_rcnt_nx;
            m_empty <= (m_rcnt_nx == m_q2);
            m_q1    <= wcnt;
            m_q2    <= m_q1;
        end
    end

    // ---------------- compare process ----------------
    logic [AW:0] prev_rptr = '0;
    always @(negedge R_CLK) begin
        check("rempty",   bus.rempty,   m_empty);
        check("rd_valid", bus.rd_valid, m_valid);
        check("rd_count", bus.rd_count, m_count);
        check("rptr",     bus.rptr,     to_gray(m_rcnt));
        check("r_addr",   bus.r_addr,   m_rcnt[AW-1:0]);
        if (m_valid) check("rd_data", bus.rd_data, m_data);
        if (!R_RST) begin
            prev_rptr <= '0;
        end else begin
            check("rptr_step", ($countones(bus.rptr ^ prev_rptr) <= 1), 1);
            prev_rptr <= bus.rptr;
        end
        // A transfer happens on the coming edge; inputs stay put until after it.
        if (bus.rd_valid && bus.rd_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_beat: got %0h expected no beat at %0t", bus.rd_data, $time);
            end else begin
                check("sb_beat", bus.rd_data, exp_q.pop_front());
            end
            hs_count++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge R_CLK);
        #1;
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        mem[wcnt[AW-1:0]] = d;
        wlog.push_back(d);
        exp_q.push_back(d);
        wcnt = wcnt + 1'b1;
        bus.wptr = to_gray(wcnt);
    endtask

    // Reset both sides together and release after two edges
    task automatic do_reset();
        bus.rd_ready = 1'b0;
        R_RST = 1'b0;
        wcnt = '0;
        bus.wptr = '0;
        exp_q.delete();
        wlog.delete();
        tick();
        tick();
        R_RST = 1'b1;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rempty"},   bus.rempty,   1);
        check({tag, "_rd_valid"}, bus.rd_valid, 0);
        check({tag, "_rptr"},     bus.rptr,     0);
        check({tag, "_r_addr"},   bus.r_addr,   0);
        check({tag, "_rd_count"}, bus.rd_count, 0);
        check({tag, "_rd_data"},  bus.rd_data,  0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        bus.wptr = '0;
        bus.rd_ready = 1'b0;
        wcnt = '0;
        for (int i = 0; i < 8; i++) mem[i] = '0;

        // Reset with no clock running
        #5 R_RST = 1'b0;
        #2 check_reset_outputs("rst_noclk");
        #3 clk_en = 1'b1;
        tick();
        tick();
        R_RST = 1'b1;
        tick();

        // Single word: 0xA5, rempty falls after E3, word out after E4
        bus.rd_ready = 1'b1;
        write_word(8'hA5);
        tick();
        tick();
        tick();
        check("single_rempty_e3", bus.rempty, 0);
        tick();
        check("single_valid_e4",  bus.rd_valid, 1);
        check("single_data_e4",   bus.rd_data,  8'hA5);
        check("single_rptr_e4",   bus.rptr,     4'b0001);
        check("single_rempty_e4", bus.rempty,   1);
        tick();
        check("single_valid_e5",  bus.rd_valid, 0);

        // Back-pressure: 8 words with the consumer stalled
        do_reset();
        for (int i = 0; i < 8; i++) begin
            write_word(8'h10 + 8'(i));
            tick();
        end
        check("bp_wptr", bus.wptr, 4'b1100);
        repeat (3) tick();
        check("bp_valid",  bus.rd_valid, 1);
        check("bp_data",   bus.rd_data,  8'h10);
        check("bp_count",  bus.rd_count, 7);
        check("bp_rempty", bus.rempty,   0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold", bus.rd_data, 8'h10);
        end
        // Release: 8 back-to-back beats
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("b2b_valid", bus.rd_valid, 1);
            check("b2b_data",  bus.rd_data,  8'h10 + 8'(i));
            tick();
        end
        check("drain_valid",  bus.rd_valid, 0);
        check("drain_rempty", bus.rempty,   1);
        check("drain_count",  bus.rd_count, 0);

        // Wrap: 20 words streamed through an 8-deep memory
        do_reset();
        bus.rd_ready = 1'b1;
        base = hs_count;
        for (int i = 0; i < 20; i++) begin
            write_word(8'(i * 37 + 5));
            tick();
        end
        repeat (8) tick();
        check("wrap_beats",  hs_count - base, 20);
        check("wrap_left",   exp_q.size(),    0);
        check("wrap_rempty", bus.rempty,      1);
        check("wrap_r_addr", bus.r_addr,      3'd4);
        check("wrap_rptr",   bus.rptr,        4'b0110);

        // Reset mid-stream with a word held and 5 waiting
        do_reset();
        for (int i = 0; i < 6; i++) begin
            write_word(8'hC0 + 8'(i));
            tick();
        end
        repeat (3) tick();
        check("mid_valid", bus.rd_valid, 1);
        check("mid_count", bus.rd_count, 5);
        check("mid_data",  bus.rd_data,  8'hC0);
        #2;
        R_RST = 1'b0;
        wcnt = '0;
        bus.wptr = '0;
        exp_q.delete();
        wlog.delete();
        #1 check_reset_outputs("rst_mid");
        tick();
        tick();
        R_RST = 1'b1;
        bus.rd_ready = 1'b1;
        base = hs_count;
        repeat (6) tick();
        check("post_rst_valid",  bus.rd_valid,    0);
        check("post_rst_beats",  hs_count - base, 0);
        check("post_rst_rempty", bus.rempty,      1);
        write_word(8'h99);
        repeat (5) tick();
        check("post_rst_new_beat", hs_count - base, 1);
        check("post_rst_idle",     bus.rd_valid,    0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller for the team's asynchronous UART FIFO, in the read clock domain. It synchronizes the Gray-coded write pointer, maintains the read pointer and empty flag, and addresses the FIFO memory's combinational read port. It presents popped words on a registered valid/ready output toward the UART transmit path. It is the counterpart of the write-side memory controller: that block writes at `w_addr` under `winc && !wfull`; this block consumes at `r_addr`.

## Interface
Parameters:
- `DATA_WIDTH`, 8, word width.
- `ADDR_WIDTH`, 3, memory address width; depth = 2^ADDR_WIDTH = 8.

Ports:
- `R_CLK`  in  1  read-domain clock; all state is on the rising edge.
- `R_RST`  in  1  asynchronous, active-low reset.
- `wptr`  in  ADDR_WIDTH+1  Gray-coded write pointer from the write clock domain (asynchronous to `R_CLK`).
- `r_data`  in  DATA_WIDTH  combinational memory read data at `r_addr`.
- `r_addr`  out  ADDR_WIDTH  memory read address; equals `rbin[ADDR_WIDTH-1:0]`.
- `rptr`  out  ADDR_WIDTH+1  registered Gray read pointer, sent to the write-domain synchronizer.
- `rempty`  out  1  registered empty flag.
- `rd_data`  out  DATA_WIDTH  output word register.
- `rd_valid`  out  1  `rd_data` holds an unconsumed word.
- `rd_ready`  in  1  consumer accepts `rd_data` this cycle.
- `rd_count`  out  ADDR_WIDTH+1  words in memory, as seen by the read domain (0..8); excludes the word held in `rd_data`.

## Operation
- **Synchronizer:** two flops, `wq1 <= wptr` and `wq2 <= wq1`. Only `wq2` is used downstream. The raw `wptr` feeds nothing else.
- **Pop condition:** `pop = !rempty && (!rd_valid || rd_ready)`.
- **On pop:** `rd_data <= r_data`, `rd_valid <= 1`, `rbin <= rbin + 1`.
  - `rbin` is ADDR_WIDTH+1 bits and wraps modulo 16.
  - The update uses the current `r_addr`, so the word is taken before the address advances.
- **Consume without pop** (`rd_valid && rd_ready && !pop`): `rd_valid <= 0`. `rd_data` holds its last value.
- **Neither pop nor consume:** `rd_valid` and `rd_data` hold. `rd_data` must stay stable while `rd_valid && !rd_ready`.
- **Pointer update:** `rbin_next = rbin + pop`; `rgray_next = rbin_next ^ (rbin_next >> 1)`; `rptr <= rgray_next`.
- **Empty:** `rempty <= (rgray_next == wq2)`. Empty is declared when all ADDR_WIDTH+1 bits are equal, including the wrap bit.
- **Count:** `rd_count = gray2bin(wq2) - rbin`, modulo 2^(ADDR_WIDTH+1), combinational from registers.
- **Pessimistic empty:** `rempty` may stay asserted up to three cycles after a write, but must never deassert while the memory is truly empty. This block never reads unwritten locations.
- **Simultaneous consume and pop:** the new word loads on the same edge and `rd_valid` stays 1, giving one word per cycle sustained.
- **Reset** (`R_RST` low, immediately, no clock needed):
  - `wq1`, `wq2`, `rbin`, `rptr`, `rd_data` = 0
  - `rd_valid` = 0
  - `rempty` = 1
  - `r_addr` = 0, `rd_count` = 0
- **Reset mid-operation:** any word in `rd_data` and all unread memory contents are discarded. The write side must be reset in the same event; a one-sided reset is unsupported.

## Timing
- **Write-to-output latency:** `wptr` changes before edge E1.
  - `wq1` updates at E1, `wq2` at E2.
  - `rempty` falls after E3.
  - Pop at E4: `rd_valid=1` and `rd_data` valid after E4.
  - Total: 4 `R_CLK` edges.
- **Throughput:** 1 word per cycle while non-empty and `rd_ready=1`.
- **`rptr` timing:** registered; it changes exactly one bit per pop, with no glitches across the clock domains.
- **Last word:** `rempty` rises on the same edge that pops the last synchronized word.
- **Handshake:** a transfer occurs on an edge where `rd_valid && rd_ready`. `rd_ready` may be held high while `rd_valid=0`, and must not be used to gate `rd_valid` combinationally.

## Test plan
- **Reset:** pulse `R_RST` low with no clock → `rempty=1`, `rd_valid=0`, `rptr=0`, `r_addr=0`, `rd_count=0`, `rd_data=0`.
- **Single word:** memory[0]=0xA5, `wptr` 0000→0001, `rd_ready=1` → `rempty` falls after E3. After E4: `rd_valid=1`, `rd_data=0xA5`, `rptr=0001`, `rempty=1`. After E5: `rd_valid=0`.
- **Back-pressure:** 8 words 0x10..0x17 written (`wptr=1100`), `rd_ready=0` → one pop only: `rd_data=0x10` held stable, `rd_count=7`, `rempty=0`. Then raise `rd_ready` → 8 consecutive beats 0x10..0x17, then `rempty=1` and `rd_count=0`.
- **Back-to-back handoff:** `rd_valid=1`, `rd_ready=1`, non-empty → `rd_valid` stays 1 and a new word loads on each edge.
- **Wrap:** stream 20 words with `wptr` advancing in Gray → output order is preserved, `r_addr` wraps 7→0, `rbin` wraps 15→0, and every `rptr` change is a single bit.
- **Reset mid-stream:** assert `R_RST` while `rd_valid=1` and `rd_count=5` → all outputs reach reset values asynchronously, and no beat is produced after release until a new write arrives.
